// File: rtl/trojan_leak_serializer.sv
// Serialises a 64-bit load word onto a single leakage bit as preamble + data + idle gap,
// each bit held BIT_CYCLES clocks, and counts completed frames.
module trojan_leak_serializer #(
  parameter int unsigned BIT_CYCLES = 4,
  parameter int unsigned GAP_CYCLES = 16,
  parameter logic [7:0]  PREAMBLE   = 8'hA5,
  parameter bit          LSB_FIRST  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [63:0] load,
  input  logic        load_valid,
  output logic        load_ready,
  output logic        leak_bit,
  output logic        leak_active,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned IDX_W  = 7;
  localparam int unsigned PER_W  = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [IDX_W-1:0] PRE_BITS    = IDX_W'(8);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(71);
  localparam logic [PER_W-1:0] PERIOD_LAST = PER_W'(BIT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRE      = 2'd1,
    DATA     = 2'd2,
    GAP      = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [PER_W-1:0]   period_q, period_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               leak_bit_q, leak_bit_d;
  logic               leak_active_q, leak_active_d;
  logic               frame_done_q, frame_done_d;
  logic [CNT_W-1:0]   frame_count_q, frame_count_d;

  logic [IDX_W-1:0]   nxt_idx;
  logic [2:0]         pre_sel;
  logic               data_bit;
  logic [CNT_W-1:0]   count_inc;
  logic [DATA_W-1:0]  shreg_shift;

  assign load_ready  = (state_q == IDLE) && enable;
  assign leak_bit    = leak_bit_q;
  assign leak_active = leak_active_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

  // Next-bit selection helpers: preamble goes MSB first, data drains from the shift register.
  always_comb begin
    nxt_idx     = idx_q + IDX_W'(1);
    pre_sel     = ~nxt_idx[2:0];
    data_bit    = LSB_FIRST ? shreg_q[0] : shreg_q[DATA_W-1];
    shreg_shift = LSB_FIRST ? {1'b0, shreg_q[DATA_W-1:1]} : {shreg_q[DATA_W-2:0], 1'b0};
    count_inc   = (frame_count_q == CNT_MAX) ? frame_count_q : frame_count_q + CNT_W'(1);
  end

  // Frame sequencing; enable low abandons the frame without counting it.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    period_d      = period_q;
    idx_d         = idx_q;
    gap_d         = gap_q;
    leak_bit_d    = leak_bit_q;
    leak_active_d = leak_active_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;

    if (!enable) begin
      state_d       = IDLE;
      period_d      = '0;
      idx_d         = '0;
      gap_d         = '0;
      leak_bit_d    = 1'b0;
      leak_active_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            state_d       = PRE;
            shreg_d       = load;
            period_d      = '0;
            idx_d         = '0;
            leak_bit_d    = PREAMBLE[7];
            leak_active_d = 1'b1;
          end
        end
        PRE, DATA: begin
          if (period_q == PERIOD_LAST) begin
            period_d = '0;
            if (idx_q == LAST_IDX) begin
              idx_d         = '0;
              leak_bit_d    = 1'b0;
              leak_active_d = 1'b0;
              if (GAP_CYCLES == 0) begin
                state_d       = IDLE;
                frame_done_d  = 1'b1;
                frame_count_d = count_inc;
              end else begin
                state_d = GAP;
                gap_d   = '0;
              end
            end else begin
              idx_d = nxt_idx;
              if (nxt_idx < PRE_BITS) begin
                leak_bit_d = PREAMBLE[pre_sel];
              end else begin
                state_d    = DATA;
                leak_bit_d = data_bit;
                shreg_d    = shreg_shift;
              end
            end
          end else begin
            period_d = period_q + PER_W'(1);
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            state_d       = IDLE;
            gap_d         = '0;
            frame_done_d  = 1'b1;
            frame_count_d = count_inc;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      period_q      <= '0;
      idx_q         <= '0;
      gap_q         <= '0;
      leak_bit_q    <= 1'b0;
      leak_active_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      period_q      <= period_d;
      idx_q         <= idx_d;
      gap_q         <= gap_d;
      leak_bit_q    <= leak_bit_d;
      leak_active_q <= leak_active_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

endmodule

// File: tb/tb_trojan_leak_serializer.sv
// Directed bench for trojan_leak_serializer: default instance plus a 1-clock/no-gap MSB-first instance.
module tb_trojan_leak_serializer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, load_valid;
  logic [63:0] load;
  logic        load_ready, leak_bit, leak_active, frame_done;
  logic [15:0] frame_count;

  logic        enable6, load_valid6;
  logic [63:0] load6;
  logic        load_ready6, leak_bit6, leak_active6, frame_done6;
  logic [15:0] frame_count6;

  trojan_leak_serializer dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .load_valid(load_valid),
    .load_ready(load_ready), .leak_bit(leak_bit), .leak_active(leak_active),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  trojan_leak_serializer #(.BIT_CYCLES(1), .GAP_CYCLES(0), .PREAMBLE(8'hA5), .LSB_FIRST(1'b0)) dut6 (
    .clk(clk), .rst(rst), .enable(enable6), .load(load6), .load_valid(load_valid6),
    .load_ready(load_ready6), .leak_bit(leak_bit6), .leak_active(leak_active6),
    .frame_done(frame_done6), .frame_count(frame_count6)
  );

  typedef struct {
    string name;
    int    j;
    logic  exp_bit;
    logic  exp_active;
    logic  exp_done;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic lb [0:319];
  logic la [0:319];
  logic fd [0:319];
  logic [15:0] fc [0:319];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic model_bit(input int j, input logic [63:0] w, input int bc, input bit lsb);
    logic [7:0] pre;
    int b;
    pre = 8'hA5;
    b   = j / bc;
    if (b < 8)  return pre[7-b];
    if (b < 72) return lsb ? w[b-8] : w[71-b];
    return 1'b0;
  endfunction

  task automatic apply_table(input vec_t tbl[$]);
    foreach (tbl[i]) begin
      check({tbl[i].name, "_bit"},    64'(lb[tbl[i].j]), 64'(tbl[i].exp_bit));
      check({tbl[i].name, "_active"}, 64'(la[tbl[i].j]), 64'(tbl[i].exp_active));
      check({tbl[i].name, "_done"},   64'(fd[tbl[i].j]), 64'(tbl[i].exp_done));
    end
  endtask

  initial begin
    vec_t v2[$];
    vec_t v6[$];
    int   bad_bit, bad_act, bad_rdy, n_done;

    v2 = '{
      '{"t2_pre0",     0, 1'b1, 1'b1, 1'b0},
      '{"t2_pre0_end", 3, 1'b1, 1'b1, 1'b0},
      '{"t2_pre1",     4, 1'b0, 1'b1, 1'b0},
      '{"t2_pre2",     8, 1'b1, 1'b1, 1'b0},
      '{"t2_pre4",    16, 1'b0, 1'b1, 1'b0},
      '{"t2_pre5",    20, 1'b1, 1'b1, 1'b0},
      '{"t2_pre7_end",31, 1'b1, 1'b1, 1'b0},
      '{"t2_d0",      32, 1'b1, 1'b1, 1'b0},
      '{"t2_d0_end",  35, 1'b1, 1'b1, 1'b0},
      '{"t2_d1",      36, 1'b0, 1'b1, 1'b0},
      '{"t2_d63_end",287, 1'b0, 1'b1, 1'b0},
      '{"t2_gap0",   288, 1'b0, 1'b0, 1'b0},
      '{"t2_gap_end",303, 1'b0, 1'b0, 1'b0},
      '{"t2_done",   304, 1'b0, 1'b0, 1'b1},
      '{"t2_after",  305, 1'b0, 1'b0, 1'b0}
    };
    v6 = '{
      '{"t6_pre0",  0, 1'b1, 1'b1, 1'b0},
      '{"t6_pre1",  1, 1'b0, 1'b1, 1'b0},
      '{"t6_pre7",  7, 1'b1, 1'b1, 1'b0},
      '{"t6_d63",   8, 1'b1, 1'b1, 1'b0},
      '{"t6_d62",   9, 1'b0, 1'b1, 1'b0},
      '{"t6_d0",   71, 1'b0, 1'b1, 1'b0},
      '{"t6_done", 72, 1'b0, 1'b0, 1'b1},
      '{"t6_after",73, 1'b0, 1'b0, 1'b0}
    };

    // 1: reset with enable high
    rst = 1'b1; enable = 1'b1; load_valid = 1'b0; load = '0;
    enable6 = 1'b1; load_valid6 = 1'b0; load6 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t1_leak_bit", 64'(leak_bit), 64'h0);
    check("t1_leak_active", 64'(leak_active), 64'h0);
    check("t1_frame_count", 64'(frame_count), 64'h0);
    check("t1_load_ready", 64'(load_ready), 64'h1);
    rst = 1'b0;

    // 2: single frame of 64'h1, load changed after accept
    load = 64'h1; load_valid = 1'b1;
    for (int j = 0; j < 310; j++) begin
      @(negedge clk);
      lb[j] = leak_bit; la[j] = leak_active; fd[j] = frame_done; fc[j] = frame_count;
      if (j == 0) begin
        check("t2_ready_busy", 64'(load_ready), 64'h0);
        load_valid = 1'b0;
        load = 64'hDEAD_BEEF_0BAD_F00D;
      end
      if (j == 304) check("t2_ready_done", 64'(load_ready), 64'h1);
    end
    apply_table(v2);
    bad_bit = 0; bad_act = 0;
    for (int j = 0; j < 305; j++) begin
      if (lb[j] !== model_bit(j, 64'h1, 4, 1'b1)) bad_bit++;
      if (la[j] !== ((j < 288) ? 1'b1 : 1'b0)) bad_act++;
    end
    check("t2_bit_sweep_errs", 64'(bad_bit), 64'h0);
    check("t2_active_sweep_errs", 64'(bad_act), 64'h0);
    check("t2_count_before", 64'(fc[303]), 64'h0);
    check("t2_count", 64'(fc[304]), 64'h1);

    // 3: back-to-back all-ones frames with load_valid held
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    load = '1; load_valid = 1'b1;
    bad_rdy = 0; bad_bit = 0; n_done = 0;
    for (int s = 0; s <= 915; s++) begin
      #1;
      if (load_ready !== ((s % 305) == 0)) bad_rdy++;
      if (frame_done) n_done++;
      if ((s % 305) >= 33 && (s % 305) <= 288 && leak_bit !== 1'b1) bad_bit++;
      if (s == 915) begin
        check("t3_count", 64'(frame_count), 64'h3);
        load_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("t3_ready_pattern_errs", 64'(bad_rdy), 64'h0);
    check("t3_data_ones_errs", 64'(bad_bit), 64'h0);
    check("t3_done_pulses", 64'(n_done), 64'h3);

    // 4: enable dropped at clock 100 of a frame
    load = 64'h1234_5678_9ABC_DEF0; load_valid = 1'b1;
    n_done = 0; bad_act = 0;
    for (int j = 0; j < 400; j++) begin
      @(negedge clk);
      if (j == 0) load_valid = 1'b0;
      if (j == 100) begin
        check("t4_abort_active", 64'(leak_active), 64'h0);
        check("t4_abort_bit", 64'(leak_bit), 64'h0);
        check("t4_ready_disabled", 64'(load_ready), 64'h0);
      end
      if (j >= 100 && leak_active) bad_act++;
      if (frame_done) n_done++;
      if (j == 99) enable = 1'b0;
    end
    check("t4_no_done", 64'(n_done), 64'h0);
    check("t4_quiet_errs", 64'(bad_act), 64'h0);
    check("t4_count_held", 64'(frame_count), 64'h3);
    enable = 1'b1; load_valid = 1'b1;
    for (int j = 0; j < 305; j++) begin
      @(negedge clk);
      if (j == 0) begin
        load_valid = 1'b0;
        check("t4_reaccept_active", 64'(leak_active), 64'h1);
        check("t4_reaccept_bit", 64'(leak_bit), 64'h1);
      end
    end
    check("t4_reaccept_done", 64'(frame_done), 64'h1);
    check("t4_reaccept_count", 64'(frame_count), 64'h4);

    // 5: reset at clock 50 of the next frame
    load_valid = 1'b1;
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      if (j == 0) load_valid = 1'b0;
      if (j == 49) rst = 1'b1;
    end
    @(negedge clk);
    check("t5_leak_bit", 64'(leak_bit), 64'h0);
    check("t5_leak_active", 64'(leak_active), 64'h0);
    check("t5_frame_done", 64'(frame_done), 64'h0);
    check("t5_frame_count", 64'(frame_count), 64'h0);
    rst = 1'b0;

    // 6: MSB-first, 1 clock/bit, no gap, saturated counter
    force dut6.frame_count_q = 16'hFFFF;
    @(negedge clk);
    release dut6.frame_count_q;
    load6 = 64'h8000_0000_0000_0000; load_valid6 = 1'b1;
    for (int j = 0; j < 80; j++) begin
      @(negedge clk);
      lb[j] = leak_bit6; la[j] = leak_active6; fd[j] = frame_done6; fc[j] = frame_count6;
      if (j == 0) load_valid6 = 1'b0;
    end
    apply_table(v6);
    bad_bit = 0;
    for (int j = 0; j < 74; j++)
      if (lb[j] !== model_bit(j, 64'h8000_0000_0000_0000, 1, 1'b0)) bad_bit++;
    check("t6_bit_sweep_errs", 64'(bad_bit), 64'h0);
    check("t6_count_saturated", 64'(fc[72]), 64'hFFFF);
    check("t6_count_later", 64'(fc[79]), 64'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
